prog_delay_line: RTL and testbench

PROG_DELAY_LINE -- requirements
Module: prog_delay_line

---
 rtl/prog_delay_line.sv | 104 ++++++++++
 tb/tb_prog_delay_line.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/prog_delay_line.sv
// Programmable delay line: MAX_DEPTH-stage {valid,data} shift register with a runtime-selected output tap.
// Latency: delay_cur enabled cycles from data_in to data_out (delay_cur=1 acts as a single D flop).
// Backpressure: none; en=0 freezes every stage, and flush/delay_load drop in-flight samples.
module prog_delay_line #(
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_DEPTH   = 8,
  parameter int RESET_DELAY = 1,
  localparam int DW         = $clog2(MAX_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  delay_load,
  input  logic [DW-1:0]         delay_sel,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [DW-1:0]         delay_cur,
  output logic                  primed
);

  logic [MAX_DEPTH-1:0]  vld_q, vld_d;
  logic [DATA_WIDTH-1:0] dat_q [MAX_DEPTH];
  logic [DATA_WIDTH-1:0] dat_d [MAX_DEPTH];
  logic [DW-1:0]         delay_cur_q, delay_cur_d;
  logic [DW-1:0]         fill_cnt_q, fill_cnt_d;
  logic [DW-1:0]         sel_clamped;

  // Clamp the requested delay into the legal 1..MAX_DEPTH range.
  always_comb begin
    sel_clamped = delay_sel;
    if (delay_sel == '0) begin
      sel_clamped = DW'(1);
    end else if (delay_sel > DW'(MAX_DEPTH)) begin
      sel_clamped = DW'(MAX_DEPTH);
    end
  end

  // Next-state: flush/load drop in-flight samples, otherwise en shifts the line and advances the fill count.
  always_comb begin
    vld_d       = vld_q;
    dat_d       = dat_q;
    delay_cur_d = delay_cur_q;
    fill_cnt_d  = fill_cnt_q;
    if (flush || delay_load) begin
      // A load keeps stale data bits; only flush scrubs the payload as well.
      vld_d      = '0;
      fill_cnt_d = '0;
      if (flush) begin
        for (int i = 0; i < MAX_DEPTH; i++) begin
          dat_d[i] = '0;
        end
      end
      if (delay_load) begin
        delay_cur_d = sel_clamped;
      end
    end else if (en) begin
      vld_d[0] = valid_in;
      dat_d[0] = data_in;
      for (int i = 1; i < MAX_DEPTH; i++) begin
        vld_d[i] = vld_q[i-1];
        dat_d[i] = dat_q[i-1];
      end
      if (fill_cnt_q < delay_cur_q) begin
        fill_cnt_d = fill_cnt_q + DW'(1);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < MAX_DEPTH; i++) begin
        dat_q[i] <= '0;
      end
      delay_cur_q <= DW'(RESET_DELAY);
      fill_cnt_q  <= '0;
    end else begin
      vld_q       <= vld_d;
      dat_q       <= dat_d;
      delay_cur_q <= delay_cur_d;
      fill_cnt_q  <= fill_cnt_d;
    end
  end

  // Output tap: select stage[delay_cur-1] straight from the registers.
  always_comb begin
    valid_out = 1'b0;
    data_out  = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (delay_cur_q == DW'(i + 1)) begin
        valid_out = vld_q[i];
        data_out  = dat_q[i];
      end
    end
  end

  assign delay_cur = delay_cur_q;
  assign primed    = (fill_cnt_q == delay_cur_q);

endmodule

// File: tb/tb_prog_delay_line.sv
// Bench for prog_delay_line: directed scenarios plus random traffic against a sample-history model.
// Latency: outputs compared every cycle on the falling edge after the model absorbs the rising edge.
// Backpressure: n/a; en, flush and delay_load are driven directly.
module tb_prog_delay_line;

  localparam int DWIDTH = 8;
  localparam int DEPTH  = 8;
  localparam int DW     = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              flush = 1'b0;
  logic              delay_load = 1'b0;
  logic [DW-1:0]     delay_sel = '0;
  logic              valid_in = 1'b0;
  logic [DWIDTH-1:0] data_in = '0;
  logic              valid_out;
  logic [DWIDTH-1:0] data_out;
  logic [DW-1:0]     delay_cur;
  logic              primed;

  prog_delay_line #(.DATA_WIDTH(DWIDTH), .MAX_DEPTH(DEPTH), .RESET_DELAY(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .delay_load(delay_load),
    .delay_sel(delay_sel), .valid_in(valid_in), .data_in(data_in),
    .valid_out(valid_out), .data_out(data_out), .delay_cur(delay_cur), .primed(primed)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              v;
    logic [DWIDTH-1:0] d;
  } smp_t;

  // Model: history of the samples accepted on enabled edges (newest at the back);
  // the output is the sample accepted dly enabled edges ago.
  smp_t hist[$];
  int   dly;
  int   cnt;
  bit   chk_on = 1'b0;
  int   n_total = 0;
  int   n_pass = 0;

  logic              exp_v;
  logic [DWIDTH-1:0] exp_d;
  int                exp_dly;
  logic              exp_primed;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  task automatic zero_hist();
    hist.delete();
    for (int i = 0; i < DEPTH; i++) hist.push_back('0);
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      zero_hist();
      dly = 1;
      cnt = 0;
      chk_on = 1'b1;
    end else if (flush || delay_load) begin
      if (flush) zero_hist();
      if (delay_load) begin
        for (int i = 0; i < hist.size(); i++) hist[i].v = 1'b0;
        if (delay_sel == 0) dly = 1;
        else if (int'(delay_sel) > DEPTH) dly = DEPTH;
        else dly = int'(delay_sel);
      end
      cnt = 0;
    end else if (en) begin
      hist.push_back({valid_in, data_in});
      if (hist.size() > DEPTH) void'(hist.pop_front());
      cnt = (cnt + 1 < dly) ? cnt + 1 : dly;
    end
    exp_v      = hist[hist.size() - dly].v;
    exp_d      = hist[hist.size() - dly].d;
    exp_dly    = dly;
    exp_primed = (cnt >= dly);
  endtask

  // One clock: apply inputs, let the model absorb the same edge, return on the falling edge.
  task automatic step(input logic r, input logic e, input logic f, input logic l,
                      input logic [DW-1:0] s, input logic vi, input logic [DWIDTH-1:0] di);
    rst_n = r; en = e; flush = f; delay_load = l; delay_sel = s; valid_in = vi; data_in = di;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("valid_out", 32'(valid_out), 32'(exp_v));
      chk("data_out", 32'(data_out), 32'(exp_d));
      chk("delay_cur", 32'(delay_cur), 32'(exp_dly));
      chk("primed", 32'(primed), 32'(exp_primed));
    end
  end

  initial begin
    // Reset then unit delay
    step(0, 0, 0, 0, 0, 0, 8'h00);
    step(0, 1, 1, 1, 4'd7, 1, 8'h55);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_primed", 32'(primed), 32'd0);
    chk("rst_delay", 32'(delay_cur), 32'd1);
    step(1, 1, 0, 0, 0, 1, 8'h11);
    chk("s1_first", {23'd0, valid_out, data_out}, 32'h111);
    chk("s1_primed", 32'(primed), 32'd1);
    step(1, 1, 0, 0, 0, 1, 8'h22);
    step(1, 1, 0, 0, 0, 1, 8'h33);
    chk("s1_third", {23'd0, valid_out, data_out}, 32'h133);

    // Delay 5 with a two-cycle stall after the third sample
    step(1, 1, 0, 1, 4'd5, 1, 8'hFF);
    for (int i = 1; i <= 10; i++) begin
      step(1, 1, 0, 0, 0, 1, 8'(i));
      if (i == 3) begin
        step(1, 0, 0, 0, 0, 1, 8'hC3);
        step(1, 0, 0, 0, 0, 0, 8'h3C);
      end
      if (i == 4) chk("s2_not_primed", 32'(primed), 32'd0);
      if (i == 5) begin
        chk("s2_primed", 32'(primed), 32'd1);
        chk("s2_first_out", {23'd0, valid_out, data_out}, 32'h101);
      end
    end

    // Clamping: 0 -> 1, 15 -> 8
    step(1, 1, 0, 1, 4'd0, 1, 8'h00);
    chk("s3_clamp_lo", 32'(delay_cur), 32'd1);
    step(1, 1, 0, 0, 0, 1, 8'h5A);
    chk("s3_lat1", {23'd0, valid_out, data_out}, 32'h15A);
    step(1, 1, 0, 1, 4'd15, 1, 8'h00);
    chk("s3_clamp_hi", 32'(delay_cur), 32'd8);
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 0, 0, 0, 1, 8'(8'h60 + i));
      if (i == 6) chk("s3_lat8_early", 32'(valid_out), 32'd0);
    end
    chk("s3_lat8", {23'd0, valid_out, data_out}, 32'h160);

    // Flush mid-stream at delay 4
    step(1, 1, 0, 1, 4'd4, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 1, 8'(8'hA0 + i));
    step(1, 1, 1, 0, 0, 0, 8'h00);
    chk("s4_flush_v0", 32'(valid_out), 32'd0);
    for (int i = 4; i < 8; i++) begin
      step(1, 1, 0, 0, 0, 1, 8'(8'hA0 + i));
      if (i < 7) chk("s4_flush_bubble", 32'(valid_out), 32'd0);
    end
    chk("s4_after_flush", {23'd0, valid_out, data_out}, 32'h1A4);

    // Flush and load together with an incoming sample
    step(1, 1, 1, 1, 4'd3, 1, 8'hEE);
    chk("s5_delay", 32'(delay_cur), 32'd3);
    chk("s5_valid", 32'(valid_out), 32'd0);
    step(1, 1, 0, 0, 0, 0, 8'h00);
    step(1, 1, 0, 0, 0, 0, 8'h00);
    chk("s5_not_primed", 32'(primed), 32'd0);
    step(1, 1, 0, 0, 0, 0, 8'h00);
    chk("s5_primed", 32'(primed), 32'd1);
    chk("s5_no_ee", 32'(data_out == 8'hEE), 32'd0);

    // Reset in the middle of a full pipeline
    step(1, 1, 0, 1, 4'd6, 0, 8'h00);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 0, 1, 8'(8'hB0 + i));
    chk("s6_full", 32'(valid_out), 32'd1);
    step(0, 1, 0, 0, 0, 1, 8'hBF);
    chk("s6_rst_out", {22'd0, valid_out, primed, data_out}, 32'h0);
    chk("s6_rst_delay", 32'(delay_cur), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0, 0, 0, 8'h00);
      chk("s6_no_old", {23'd0, valid_out, data_out}, 32'h0);
    end

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 99) < 3),
           ($urandom_range(0, 99) < 4),
           DW'($urandom_range(0, 15)),
           1'($urandom),
           8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
